// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter onto a single-cycle memory port
// Port 0 is a read-only fetch port, port 1 a read/write data port; one access per three cycles.
module mem_arbiter #(
   parameter int ADDRSIZE = 64,
   parameter int WORDSIZE = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDRSIZE-1:0] if_addr,
   output logic                if_ack,
   output logic [WORDSIZE-1:0] if_rdata,
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDRSIZE-1:0] dm_addr,
   input  logic [WORDSIZE-1:0] dm_wdata,
   output logic                dm_ack,
   output logic [WORDSIZE-1:0] dm_rdata,
   output logic                mem_wren,
   output logic                mem_rden,
   output logic [ADDRSIZE-1:0] mem_addr,
   output logic [WORDSIZE-1:0] mem_d,
   input  logic [WORDSIZE-1:0] mem_q,
   output logic                busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                gnt_q, gnt_d;
   logic                if_ack_q, if_ack_d;
   logic                dm_ack_q, dm_ack_d;
   logic [WORDSIZE-1:0] if_rdata_q, if_rdata_d;
   logic [WORDSIZE-1:0] dm_rdata_q, dm_rdata_d;
   logic                mem_wren_q, mem_wren_d;
   logic                mem_rden_q, mem_rden_d;
   logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
   logic [WORDSIZE-1:0] mem_d_q, mem_d_d;
   logic                busy_q, busy_d;
   logic                win;
   logic                win_wr;

   // win = 1 selects port 1; on a tie the port that did not win last time goes
   assign win    = (if_req && dm_req) ? ~last_q : dm_req;
   assign win_wr = win & dm_we;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      gnt_d      = gnt_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      if_ack_d   = 1'b0;
      dm_ack_d   = 1'b0;
      mem_wren_d = 1'b0;
      mem_rden_d = 1'b0;
      mem_addr_d = '0;
      mem_d_d    = '0;
      busy_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (if_req || dm_req) begin
               gnt_d      = win;
               last_d     = win;
               mem_wren_d = win_wr;
               mem_rden_d = ~win_wr;
               mem_addr_d = win ? dm_addr : if_addr;
               mem_d_d    = win_wr ? dm_wdata : '0;
               busy_d     = 1'b1;
               state_d    = ACCESS;
            end
         end
         ACCESS: begin
            // mem_wren_q doubles as the latched direction of the current access
            if (!mem_wren_q) begin
               if (gnt_q) dm_rdata_d = mem_q;
               else       if_rdata_d = mem_q;
            end
            if_ack_d = ~gnt_q;
            dm_ack_d = gnt_q;
            busy_d   = 1'b1;
            state_d  = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         gnt_q      <= 1'b0;
         if_ack_q   <= 1'b0;
         dm_ack_q   <= 1'b0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
         mem_wren_q <= 1'b0;
         mem_rden_q <= 1'b0;
         mem_addr_q <= '0;
         mem_d_q    <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         gnt_q      <= gnt_d;
         if_ack_q   <= if_ack_d;
         dm_ack_q   <= dm_ack_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
         mem_wren_q <= mem_wren_d;
         mem_rden_q <= mem_rden_d;
         mem_addr_q <= mem_addr_d;
         mem_d_q    <= mem_d_d;
         busy_q     <= busy_d;
      end
   end

   assign if_ack   = if_ack_q;
   assign dm_ack   = dm_ack_q;
   assign if_rdata = if_rdata_q;
   assign dm_rdata = dm_rdata_q;
   assign mem_wren = mem_wren_q;
   assign mem_rden = mem_rden_q;
   assign mem_addr = mem_addr_q;
   assign mem_d    = mem_d_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter
// Expected acks are queued when a request is driven and retired by a negedge monitor.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req = 1'b0;
   logic [63:0] if_addr = '0;
   logic        if_ack;
   logic [63:0] if_rdata;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [63:0] dm_addr = '0;
   logic [63:0] dm_wdata = '0;
   logic        dm_ack;
   logic [63:0] dm_rdata;
   logic        mem_wren;
   logic        mem_rden;
   logic [63:0] mem_addr;
   logic [63:0] mem_d;
   logic [63:0] mem_q;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic        port;
      logic [63:0] rdata;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   logic [63:0] ram [0:255];

   mem_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr), .mem_d(mem_d),
      .mem_q(mem_q), .busy(busy)
   );

   always #5 clk = ~clk;

   // Address 0x8 is a fixed ROM word holding 0x13
   assign mem_q = !mem_rden ? 64'h0 :
                  (mem_addr == 64'h8) ? 64'h13 : ram[mem_addr[7:0]];

   always @(posedge clk) begin
      if (mem_wren) ram[mem_addr[7:0]] <= mem_d;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("ack_overlap", {63'b0, if_ack & dm_ack}, 64'h0);
         chk("wren_rden_both", {63'b0, mem_wren & mem_rden}, 64'h0);
         if (!mem_wren && !mem_rden) begin
            chk("idle_mem_addr", mem_addr, 64'h0);
            chk("idle_mem_d", mem_d, 64'h0);
         end
         if (if_ack || dm_ack) begin
            chk("ack_expected", {63'b0, sb.size() != 0}, 64'h1);
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               chk("ack_port", {63'b0, dm_ack}, {63'b0, mon_e.port});
               chk("ack_rdata", mon_e.port ? dm_rdata : if_rdata, mon_e.rdata);
            end
         end
      end
   end

   task automatic do_access(input string tag, input logic port, input logic we,
                            input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [63:0] exp_rd);
      int   n;
      logic seen;
      logic wr;
      wr = port & we;
      sb.push_back('{port, exp_rd});
      if (port) begin
         dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wdata;
      end else begin
         if_req = 1'b1; if_addr = addr;
      end
      n = 0;
      seen = 1'b0;
      while (!seen && n < 10) begin
         tick();
         n++;
         if (n == 1) begin
            chk({tag, "_wren"}, {63'b0, mem_wren}, {63'b0, wr});
            chk({tag, "_rden"}, {63'b0, mem_rden}, {63'b0, ~wr});
            chk({tag, "_addr"}, mem_addr, addr);
            chk({tag, "_d"}, mem_d, wr ? wdata : 64'h0);
            chk({tag, "_busy"}, {63'b0, busy}, 64'h1);
         end
         seen = port ? dm_ack : if_ack;
      end
      chk({tag, "_latency"}, 64'(n), 64'd2);
      if_req = 1'b0;
      dm_req = 1'b0;
      dm_we  = 1'b0;
      tick();
      chk({tag, "_busy_after"}, {63'b0, busy}, 64'h0);
   endtask

   initial begin
      #1;
      chk("rst_if_ack", {63'b0, if_ack}, 64'h0);
      chk("rst_dm_ack", {63'b0, dm_ack}, 64'h0);
      chk("rst_wren", {63'b0, mem_wren}, 64'h0);
      chk("rst_rden", {63'b0, mem_rden}, 64'h0);
      chk("rst_addr", mem_addr, 64'h0);
      chk("rst_d", mem_d, 64'h0);
      chk("rst_if_rdata", if_rdata, 64'h0);
      chk("rst_dm_rdata", dm_rdata, 64'h0);
      chk("rst_busy", {63'b0, busy}, 64'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      tick();

      do_access("wr_10", 1'b1, 1'b1, 64'h10, 64'hDEADBEEF, 64'h0);
      do_access("rd_10", 1'b1, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF);
      do_access("if_rd_8", 1'b0, 1'b0, 64'h8, 64'h0, 64'h13);
      do_access("wr_20", 1'b1, 1'b1, 64'h20, 64'h55, 64'hDEADBEEF);
      do_access("rd_20", 1'b1, 1'b0, 64'h20, 64'h0, 64'h55);
      do_access("if_rd_10", 1'b0, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF);

      // Port 1 raises its request while port 0 is in RESP
      sb.push_back('{1'b0, 64'h13});
      if_req = 1'b1; if_addr = 64'h8;
      tick();
      tick();
      chk("rsp_if_ack", {63'b0, if_ack}, 64'h1);
      if_req = 1'b0;
      sb.push_back('{1'b1, 64'hDEADBEEF});
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h10;
      tick();
      chk("rsp_idle_busy", {63'b0, busy}, 64'h0);
      chk("rsp_idle_dm_ack", {63'b0, dm_ack}, 64'h0);
      tick();
      chk("rsp_dm_rden", {63'b0, mem_rden}, 64'h1);
      chk("rsp_dm_addr", mem_addr, 64'h10);
      tick();
      chk("rsp_dm_ack", {63'b0, dm_ack}, 64'h1);
      dm_req = 1'b0;
      tick();

      // Reset asserted in the middle of an ACCESS cycle
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h30; dm_wdata = 64'h77;
      tick();
      chk("abort_wren_before", {63'b0, mem_wren}, 64'h1);
      rst = 1'b0;
      #1;
      chk("abort_wren", {63'b0, mem_wren}, 64'h0);
      chk("abort_rden", {63'b0, mem_rden}, 64'h0);
      chk("abort_busy", {63'b0, busy}, 64'h0);
      chk("abort_addr", mem_addr, 64'h0);
      chk("abort_d", mem_d, 64'h0);
      chk("abort_dm_rdata", dm_rdata, 64'h0);
      chk("abort_if_rdata", if_rdata, 64'h0);
      dm_req = 1'b0; dm_we = 1'b0;
      tick();
      tick();
      chk("abort_no_dm_ack", {63'b0, dm_ack}, 64'h0);
      chk("abort_no_if_ack", {63'b0, if_ack}, 64'h0);
      rst = 1'b1;

      // Both ports held high: port 0 wins first, then grants alternate
      sb.push_back('{1'b0, 64'h13});
      sb.push_back('{1'b1, 64'h55});
      sb.push_back('{1'b0, 64'h13});
      sb.push_back('{1'b1, 64'h55});
      if_req = 1'b1; if_addr = 64'h8;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h20;
      for (int n = 1; n <= 11; n++) begin
         tick();
         chk($sformatf("rr_if_ack_c%0d", n), {63'b0, if_ack}, {63'b0, (n == 2) || (n == 8)});
         chk($sformatf("rr_dm_ack_c%0d", n), {63'b0, dm_ack}, {63'b0, (n == 5) || (n == 11)});
      end
      if_req = 1'b0;
      dm_req = 1'b0;
      tick();

      do_access("post_rst_rd", 1'b1, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF);
      chk("if_rdata_hold", if_rdata, 64'h13);

      repeat (2) tick();
      chk("sb_drained", 64'(sb.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDRSIZE, default 64, is the address width of both requester ports and the memory port.
REQ-002 Parameter WORDSIZE, default 64, is the data width of both requester ports and the memory port.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 if_req  input  1  instruction-fetch (port 0) request; held high until if_ack.
REQ-006 if_addr  input  ADDRSIZE  port 0 address; stable while if_req is high.
REQ-007 if_ack  output  1  port 0 completion; high exactly one cycle per access.
REQ-008 if_rdata  output  WORDSIZE  port 0 read data; valid while if_ack is high.
REQ-009 dm_req  input  1  data-memory (port 1) request; held high until dm_ack.
REQ-010 dm_we  input  1  port 1 direction: 1 = write, 0 = read; stable while dm_req is high.
REQ-011 dm_addr  input  ADDRSIZE  port 1 address; stable while dm_req is high.
REQ-012 dm_wdata  input  WORDSIZE  port 1 write data; stable while dm_req is high.
REQ-013 dm_ack  output  1  port 1 completion; high exactly one cycle per access.
REQ-014 dm_rdata  output  WORDSIZE  port 1 read data; valid while dm_ack is high and the access was a read.
REQ-015 mem_wren  output  1  memory write enable.
REQ-016 mem_rden  output  1  memory read enable.
REQ-017 mem_addr  output  ADDRSIZE  memory address.
REQ-018 mem_d  output  WORDSIZE  memory write data.
REQ-019 mem_q  input  WORDSIZE  memory read data; combinational from mem_addr while mem_rden is high.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-022 IDLE: on a clock edge with any request high, latch the winning port, address, write data and direction; go to ACCESS. With no request, stay in IDLE.
REQ-023 Port 0 is always a read; the latched direction for port 0 SHALL be read.
REQ-024 Arbitration SHALL be round-robin with a 1-bit last-grant pointer: a lone requester wins; when both request, the port not equal to last-grant wins; last-grant updates on every grant.
REQ-025 ACCESS lasts exactly one cycle: mem_addr = latched address; mem_wren = 1 for a write; mem_rden = 1 for a read; never both high.
REQ-026 At the edge ending ACCESS, mem_q SHALL be captured into the granted port's rdata register on a read; go to RESP.
REQ-027 RESP lasts exactly one cycle: the granted port's ack = 1, the other ack = 0; return to IDLE.
REQ-028 Latency from the first edge sampling req high (port uncontended) to ack high SHALL be 2 cycles; one access completes per 3 cycles.
REQ-029 mem_wren and mem_rden SHALL be 0 in IDLE and RESP; mem_addr and mem_d SHALL be 0 outside ACCESS.
REQ-030 if_rdata and dm_rdata SHALL hold their last captured value until the next read on that port; a write does not alter dm_rdata.
REQ-031 A requester that keeps req high through RESP SHALL be treated as a new request in the following IDLE cycle and is subject to arbitration.
REQ-032 Requests arriving while busy SHALL wait and never be dropped; the losing port is granted next if still requesting.
REQ-033 Address and data pass unmodified; no width conversion or wrap.

Reset
REQ-034 rst low SHALL immediately, without a clock, force state = IDLE, last-grant = port 1 (port 0 wins the first tie), all acks = 0, mem_wren = mem_rden = 0, mem_addr = mem_d = 0, if_rdata = dm_rdata = 0 and busy = 0.
REQ-035 Reset during ACCESS SHALL abort the access with no ack; the interrupted write is not guaranteed complete.
REQ-036 After rst rises, the first access SHALL start no earlier than the first clock edge with rst high.

Verification
REQ-037 Port 1 write, addr 0x10, data 0xDEADBEEF -> ACCESS shows mem_wren=1, mem_addr=0x10, mem_d=0xDEADBEEF; dm_ack 2 cycles after sampling.
REQ-038 Port 1 read of 0x10 after that write -> mem_rden=1 in ACCESS; dm_ack with dm_rdata=0xDEADBEEF.
REQ-039 Both ports request from reset, held continuously -> grants alternate 0,1,0,1; each ack every 6 cycles.
REQ-040 Port 0 reads 0x8 (mem holds 0x13) while port 1 idle -> if_ack with if_rdata=0x13; dm_ack stays 0.
REQ-041 rst pulsed low mid-ACCESS -> mem_wren/mem_rden drop to 0 asynchronously, no ack, busy=0; a fresh request afterwards completes normally.
REQ-042 dm_req rises during a port 0 RESP -> port 1 granted in the next IDLE edge; if_ack never overlaps dm_ack.
